inst_fetch_queue: RTL and testbench

//  Front end ahead of the decoder: fetches instruction words from memory control, predicts next PC
//  (JAL always taken; BRANCH via 2-bit saturating BHT), queues {inst, pc, predict} in a FIFO.

---
 rtl/inst_fetch_queue.sv | 173 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: fetches words from memory control, predecodes them to
// predict the next PC (JAL always taken, BRANCH via a 2-bit saturating BHT) and
// buffers {inst, pc, predict} entries for the decoder. The ROB trains the BHT on
// branch commit and flushes the queue on a mispredict.
module inst_fetch_queue #(
    parameter int          IQ_DEPTH = 4,
    parameter int          BHT_BITS = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        mc_en,
    output logic [31:0] mc_addr,
    input  logic        mc_rdy,
    input  logic [31:0] mc_data,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_predict,
    input  logic        bp_upd_en,
    input  logic [31:0] bp_upd_pc,
    input  logic        bp_upd_taken
);

    localparam int               PTR_W      = $clog2(IQ_DEPTH);
    localparam int               CNT_W      = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(IQ_DEPTH);
    localparam int               BHT_SIZE   = 1 << BHT_BITS;
    localparam logic [6:0]       OPC_JAL    = 7'b1101111;
    localparam logic [6:0]       OPC_BRANCH = 7'b1100011;

    logic [31:0]      pc_q, pc_d;
    logic             gap_q, gap_d;
    logic [PTR_W-1:0] headPtr_q, headPtr_d;
    logic [PTR_W-1:0] tailPtr_q, tailPtr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] instMem_q [IQ_DEPTH];
    logic [31:0] pcMem_q   [IQ_DEPTH];
    logic        predMem_q [IQ_DEPTH];
    logic [1:0]  bhtCnt_q  [BHT_SIZE];

    logic [BHT_BITS-1:0] lookupIdx;
    logic [BHT_BITS-1:0] updIdx;
    logic [31:0]         immJ;
    logic [31:0]         immB;
    logic                predTaken;
    logic [31:0]         nextPc;
    logic                pushEn;
    logic                popEn;
    logic                unusedUpdPcBits;

    // Only the index bits of the training PC select a counter; the rest is ignored.
    assign unusedUpdPcBits = ^{bp_upd_pc[31:BHT_BITS+2], bp_upd_pc[1:0]};

    assign lookupIdx = pc_q[BHT_BITS+1:2];
    assign updIdx    = bp_upd_pc[BHT_BITS+1:2];

    assign mc_en     = (count_q < FULL_COUNT) && !gap_q;
    assign mc_addr   = pc_q;
    assign dec_valid = (count_q != '0);

    // A flush wins over push and pop; the frozen state (rdy_in=0) accepts neither.
    assign pushEn = rdy_in && !flush && mc_en && mc_rdy;
    assign popEn  = rdy_in && !flush && dec_valid && dec_ready;

    // Head entry is shown only while valid so an empty queue presents all zeros.
    always_comb begin
        dec_inst    = '0;
        dec_pc      = '0;
        dec_predict = 1'b0;
        if (dec_valid) begin
            dec_inst    = instMem_q[headPtr_q];
            dec_pc      = pcMem_q[headPtr_q];
            dec_predict = predMem_q[headPtr_q];
        end
    end

    // Predecode the returning word to choose the predicted next fetch address.
    always_comb begin
        immJ      = {{11{mc_data[31]}}, mc_data[31], mc_data[19:12], mc_data[20],
                     mc_data[30:21], 1'b0};
        immB      = {{19{mc_data[31]}}, mc_data[31], mc_data[7], mc_data[30:25],
                     mc_data[11:8], 1'b0};
        predTaken = 1'b0;
        nextPc    = pc_q + 32'd4;
        if (mc_data[6:0] == OPC_JAL) begin
            predTaken = 1'b1;
            nextPc    = pc_q + immJ;
        end else if (mc_data[6:0] == OPC_BRANCH) begin
            predTaken = bhtCnt_q[lookupIdx][1];
            nextPc    = predTaken ? (pc_q + immB) : (pc_q + 32'd4);
        end
    end

    // Next-state logic for the fetch PC, the bubble flag and the queue pointers.
    always_comb begin
        pc_d      = pc_q;
        gap_d     = gap_q;
        headPtr_d = headPtr_q;
        tailPtr_d = tailPtr_q;
        count_d   = count_q;
        if (rdy_in) begin
            if (flush) begin
                pc_d      = flush_pc;
                gap_d     = 1'b1;
                headPtr_d = '0;
                tailPtr_d = '0;
                count_d   = '0;
            end else begin
                gap_d = 1'b0;
                if (pushEn) begin
                    pc_d      = nextPc;
                    tailPtr_d = tailPtr_q + PTR_W'(1);
                end
                if (popEn) begin
                    headPtr_d = headPtr_q + PTR_W'(1);
                end
                if (pushEn && !popEn) begin
                    count_d = count_q + CNT_W'(1);
                end else if (popEn && !pushEn) begin
                    count_d = count_q - CNT_W'(1);
                end
            end
        end
    end

    // Control registers; reset acts regardless of rdy_in and starts with a bubble.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pc_q      <= RESET_PC;
            gap_q     <= 1'b1;
            headPtr_q <= '0;
            tailPtr_q <= '0;
            count_q   <= '0;
        end else begin
            pc_q      <= pc_d;
            gap_q     <= gap_d;
            headPtr_q <= headPtr_d;
            tailPtr_q <= tailPtr_d;
            count_q   <= count_d;
        end
    end

    // Queue storage is written at the tail on an accepted fetch.
    always_ff @(posedge clk_in) begin
        if (!rst_in && pushEn) begin
            instMem_q[tailPtr_q] <= mc_data;
            pcMem_q[tailPtr_q]   <= pc_q;
            predMem_q[tailPtr_q] <= predTaken;
        end
    end

    // Branch history counters start weakly not-taken and saturate at 0 and 3.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BHT_SIZE; i++) begin
                bhtCnt_q[i] <= 2'b01;
            end
        end else if (rdy_in && bp_upd_en) begin
            if (bp_upd_taken && (bhtCnt_q[updIdx] != 2'b11)) begin
                bhtCnt_q[updIdx] <= bhtCnt_q[updIdx] + 2'b01;
            end else if (!bp_upd_taken && (bhtCnt_q[updIdx] != 2'b00)) begin
                bhtCnt_q[updIdx] <= bhtCnt_q[updIdx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Testbench for inst_fetch_queue: a table of fetch vectors walks the predecode and
// next-PC paths, a scoreboard checks every entry the decoder pops, and hand-written
// sequences cover BHT training, back-pressure, flush, freeze and reset.
module tb_inst_fetch_queue;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic        flush;
    logic [31:0] flush_pc;
    logic        mc_en;
    logic [31:0] mc_addr;
    logic        mc_rdy;
    logic [31:0] mc_data;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_predict;
    logic        bp_upd_en;
    logic [31:0] bp_upd_pc;
    logic        bp_upd_taken;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] BR_M4    = 32'hFE00_0EE3;
    localparam logic [31:0] BR_PC    = 32'h0000_0020;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        predict;
    } entry_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        predict;
    } vec_t;

    entry_t sbQ [$];
    entry_t expEntry;
    vec_t   vecs [10];
    int     checks = 0;
    int     errors = 0;

    inst_fetch_queue #(
        .IQ_DEPTH (4),
        .BHT_BITS (6),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .rdy_in       (rdy_in),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .mc_en        (mc_en),
        .mc_addr      (mc_addr),
        .mc_rdy       (mc_rdy),
        .mc_data      (mc_data),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_inst     (dec_inst),
        .dec_pc       (dec_pc),
        .dec_predict  (dec_predict),
        .bp_upd_en    (bp_upd_en),
        .bp_upd_pc    (bp_upd_pc),
        .bp_upd_taken (bp_upd_taken)
    );

    // Free-running clock.
    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Hard time limit so a stuck design can never hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, got no summary expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Scoreboard: every real pop must match the oldest entry the bench expects.
    always @(negedge clk_in) begin
        if (rdy_in && !rst_in && !flush && dec_valid && dec_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected pop: got pc 0x%08h expected no entry", dec_pc);
            end else begin
                expEntry = sbQ.pop_front();
                checkOutput("pop inst", dec_inst, expEntry.inst);
                checkOutput("pop pc", dec_pc, expEntry.pc);
                checkOutput("pop predict", 32'(dec_predict), 32'(expEntry.predict));
            end
        end
    end

    task automatic waitFetchEnable();
        int n = 0;
        while (mc_en !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (mc_en !== 1'b1) checkOutput("mc_en wait timeout", 32'(mc_en), 32'd1);
    endtask

    // Answer one fetch request and record the entry the decoder should see.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic pred);
        entry_t e;
        waitFetchEnable();
        checkOutput("mc_addr", mc_addr, addr);
        mc_rdy  = 1'b1;
        mc_data = data;
        e.inst = data;
        e.pc = addr;
        e.predict = pred;
        sbQ.push_back(e);
        tick();
        mc_rdy  = 1'b0;
        mc_data = 32'h0;
    endtask

    task automatic doFlush(input logic [31:0] pc, input logic withWord);
        flush    = 1'b1;
        flush_pc = pc;
        mc_rdy   = withWord;
        mc_data  = NOP;
        sbQ.delete();
        tick();
        flush   = 1'b0;
        mc_rdy  = 1'b0;
        mc_data = 32'h0;
        checkOutput("flush dec_valid", 32'(dec_valid), 32'd0);
        checkOutput("flush bubble mc_en", 32'(mc_en), 32'd0);
        tick();
        checkOutput("post-flush mc_en", 32'(mc_en), 32'd1);
        checkOutput("post-flush mc_addr", mc_addr, pc);
    endtask

    task automatic trainBranch(input logic taken, input int n);
        for (int k = 0; k < n; k++) begin
            bp_upd_en    = 1'b1;
            bp_upd_pc    = BR_PC;
            bp_upd_taken = taken;
            tick();
        end
        bp_upd_en = 1'b0;
    endtask

    task automatic checkBranchPredict(input logic pred);
        doFlush(BR_PC, 1'b0);
        applyStimulus(BR_PC, BR_M4, pred);
        waitFetchEnable();
        checkOutput("branch next mc_addr", mc_addr, pred ? 32'h0000_001C : 32'h0000_0024);
    endtask

    task automatic drainQueue();
        int n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        checkOutput("drain leftover", 32'(sbQ.size()), 32'd0);
        checkOutput("drained dec_valid", 32'(dec_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, NOP,           1'b0};
        vecs[1] = '{32'h0000_0004, NOP,           1'b0};
        vecs[2] = '{32'h0000_0008, NOP,           1'b0};
        vecs[3] = '{32'h0000_000C, 32'h0040_006F, 1'b1};
        vecs[4] = '{32'h0000_0010, 32'h0080_006F, 1'b1};
        vecs[5] = '{32'h0000_0018, 32'h0080_006F, 1'b1};
        vecs[6] = '{32'h0000_0020, BR_M4,         1'b0};
        vecs[7] = '{32'h0000_0024, NOP,           1'b0};
        vecs[8] = '{32'h0000_0028, 32'h0000_8067, 1'b0};
        vecs[9] = '{32'h0000_002C, 32'hFF9F_F06F, 1'b1};

        rst_in = 1'b1;  rdy_in = 1'b1;  flush = 1'b0;  flush_pc = 32'h0;
        mc_rdy = 1'b0;  mc_data = 32'h0;  dec_ready = 1'b0;
        bp_upd_en = 1'b0;  bp_upd_pc = 32'h0;  bp_upd_taken = 1'b0;
        tick();
        tick();
        rst_in = 1'b0;
        checkOutput("reset mc_en", 32'(mc_en), 32'd0);
        checkOutput("reset mc_addr", mc_addr, 32'h0);
        checkOutput("reset dec_valid", 32'(dec_valid), 32'd0);
        checkOutput("reset dec_inst", dec_inst, 32'h0);
        checkOutput("reset dec_pc", dec_pc, 32'h0);
        checkOutput("reset dec_predict", 32'(dec_predict), 32'd0);
        tick();
        checkOutput("after bubble mc_en", 32'(mc_en), 32'd1);

        dec_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].predict);
            if (i == 0) begin
                checkOutput("first entry valid", 32'(dec_valid), 32'd1);
                checkOutput("first entry pc", dec_pc, 32'h0);
            end
        end
        waitFetchEnable();
        checkOutput("mc_addr after table", mc_addr, 32'h0000_0024);

        doFlush(32'h0000_0100, 1'b1);

        trainBranch(1'b1, 2);
        checkBranchPredict(1'b1);
        trainBranch(1'b1, 5);
        trainBranch(1'b0, 1);
        checkBranchPredict(1'b1);
        trainBranch(1'b0, 1);
        checkBranchPredict(1'b0);
        trainBranch(1'b0, 3);
        trainBranch(1'b1, 1);
        checkBranchPredict(1'b0);

        dec_ready = 1'b0;
        doFlush(32'h0000_0040, 1'b0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(32'h40 + 32'(4 * k), NOP | (32'(k + 1) << 20), 1'b0);
        end
        checkOutput("full mc_en", 32'(mc_en), 32'd0);
        checkOutput("full head pc", dec_pc, 32'h0000_0040);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        checkOutput("mc_en after pop", 32'(mc_en), 32'd1);
        checkOutput("mc_addr after pop", mc_addr, 32'h0000_0050);
        dec_ready = 1'b1;
        applyStimulus(32'h0000_0050, 32'h0500_0013, 1'b0);
        dec_ready = 1'b0;
        checkOutput("push+pop head pc", dec_pc, 32'h0000_0048);
        checkOutput("push+pop mc_en", 32'(mc_en), 32'd1);
        applyStimulus(32'h0000_0054, 32'h0600_0013, 1'b0);
        checkOutput("refill mc_en", 32'(mc_en), 32'd0);
        dec_ready = 1'b1;
        drainQueue();

        dec_ready = 1'b0;
        applyStimulus(32'h0000_0058, 32'h0700_0013, 1'b0);
        rdy_in = 1'b0;  dec_ready = 1'b1;  mc_rdy = 1'b1;  mc_data = 32'h0080_006F;
        flush = 1'b1;  flush_pc = 32'h0000_0200;
        bp_upd_en = 1'b1;  bp_upd_pc = BR_PC;  bp_upd_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("freeze mc_addr", mc_addr, 32'h0000_005C);
            checkOutput("freeze dec_valid", 32'(dec_valid), 32'd1);
            checkOutput("freeze dec_pc", dec_pc, 32'h0000_0058);
        end
        rdy_in = 1'b1;  mc_rdy = 1'b0;  mc_data = 32'h0;  flush = 1'b0;  bp_upd_en = 1'b0;
        tick();
        checkOutput("unfreeze mc_addr", mc_addr, 32'h0000_005C);
        checkOutput("unfreeze dec_valid", 32'(dec_valid), 32'd0);
        checkBranchPredict(1'b0);

        trainBranch(1'b1, 2);
        dec_ready = 1'b0;
        applyStimulus(32'h0000_0024, NOP, 1'b0);
        rdy_in = 1'b0;
        rst_in = 1'b1;
        sbQ.delete();
        tick();
        rst_in = 1'b0;
        rdy_in = 1'b1;
        checkOutput("frozen reset mc_en", 32'(mc_en), 32'd0);
        checkOutput("frozen reset mc_addr", mc_addr, 32'h0);
        checkOutput("frozen reset dec_valid", 32'(dec_valid), 32'd0);
        checkOutput("frozen reset dec_pc", dec_pc, 32'h0);
        tick();
        checkOutput("frozen reset refetch mc_en", 32'(mc_en), 32'd1);
        checkOutput("frozen reset refetch mc_addr", mc_addr, 32'h0);
        dec_ready = 1'b1;
        checkBranchPredict(1'b0);

        tick();
        checkOutput("scoreboard empty", 32'(sbQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
